proc_param: RTL

//  Parametrised successor to the 9-bit bus processor: W-bit datapath, eight general registers R0..R7,
//  A/G/IR registers, one shared bus, and a multi-cycle control FSM with a Run/Done handshake.
//  The instruction set grows from mv/mvi/add/sub to eight opcodes, and ALU flags Z/N/C are now kept.

---
 rtl/proc_param_pkg.sv | 38 +++
 rtl/proc_alu.sv | 38 +++
 rtl/proc_param.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/proc_param_pkg.sv
// Shared opcodes, FSM states, flag positions and the per-cycle control word
// for the parametrised bus processor.
package proc_param_pkg;

  localparam int unsigned IR_W     = 9;
  localparam int unsigned OP_W     = 3;
  localparam int unsigned IDX_W    = 3;
  localparam int unsigned NUM_REGS = 8;
  localparam int unsigned FLAG_W   = 3;

  localparam logic [OP_W-1:0] OP_MV   = 3'b000;
  localparam logic [OP_W-1:0] OP_MVI  = 3'b001;
  localparam logic [OP_W-1:0] OP_ADD  = 3'b010;
  localparam logic [OP_W-1:0] OP_SUB  = 3'b011;
  localparam logic [OP_W-1:0] OP_AND  = 3'b100;
  localparam logic [OP_W-1:0] OP_XOR  = 3'b101;
  localparam logic [OP_W-1:0] OP_MVNZ = 3'b110;
  localparam logic [OP_W-1:0] OP_SL   = 3'b111;

  localparam int unsigned FZ = 2;
  localparam int unsigned FN = 1;
  localparam int unsigned FC = 0;

  typedef enum logic [1:0] {T0, T1, T2, T3} state_e;

  // One cycle's worth of bus-source enables and register loads
  typedef struct packed {
    logic [NUM_REGS-1:0] r_out;
    logic                din_out;
    logic                g_out;
    logic [NUM_REGS-1:0] r_in;
    logic                a_in;
    logic                g_in;
    logic                ir_in;
    logic                done;
  } ctrl_t;

endpackage

// File: rtl/proc_alu.sv
// Combinational ALU for the bus processor: add/sub/and/xor/shift-left with Z/N/C.
module proc_alu
  import proc_param_pkg::*;
#(
  parameter int unsigned W = 9
) (
  input  logic [OP_W-1:0] op_i,
  input  logic [W-1:0]    a_i,
  input  logic [W-1:0]    b_i,
  output logic [W-1:0]    s_o,
  output logic            z_o,
  output logic            n_o,
  output logic            c_o
);

  localparam int unsigned EXT_W = W + 1;

  logic [EXT_W-1:0] ext;

  // Bit W of ext is the carry; subtraction as A + ~B + 1 leaves NOT-borrow there
  always_comb begin
    ext = '0;
    case (op_i)
      OP_ADD:  ext = {1'b0, a_i} + {1'b0, b_i};
      OP_SUB:  ext = {1'b0, a_i} + {1'b0, ~b_i} + EXT_W'(1);
      OP_AND:  ext = {1'b0, a_i & b_i};
      OP_XOR:  ext = {1'b0, a_i ^ b_i};
      OP_SL:   ext = {a_i, 1'b0};
      default: ext = '0;
    endcase
  end

  assign s_o = ext[W-1:0];
  assign c_o = ext[W];
  assign z_o = (ext[W-1:0] == '0);
  assign n_o = ext[W-1];

endmodule

// File: rtl/proc_param.sv
// W-bit multi-cycle bus processor: R0..R7, A, G, IR, Flags, one-hot bus mux
// and a T0..T3 control sequencer with a Run/Done handshake.
module proc_param
  import proc_param_pkg::*;
#(
  parameter int unsigned W = 9
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic             Run,
  input  logic [W-1:0]     DIN,
  output logic             Done,
  output logic [W-1:0]     BusWires,
  output logic [FLAG_W-1:0] Flags
);

  state_e              state_q, state_d;
  logic [IR_W-1:0]     ir_q;
  logic [W-1:0]        r_q [NUM_REGS];
  logic [W-1:0]        a_q;
  logic [W-1:0]        g_q;
  logic [FLAG_W-1:0]   flags_q;

  ctrl_t               ctrl;
  logic [W-1:0]        bus;
  logic [OP_W-1:0]     op;
  logic [IDX_W-1:0]    rx;
  logic [IDX_W-1:0]    ry;
  logic [W-1:0]        alu_s;
  logic                alu_z, alu_n, alu_c;

  assign op = ir_q[IR_W-1 -: OP_W];
  assign rx = ir_q[IR_W-OP_W-1 -: IDX_W];
  assign ry = ir_q[IDX_W-1:0];

  // Step decode: bus source, loads and Done for the current state and opcode
  always_comb begin
    state_d = state_q;
    ctrl    = '0;
    case (state_q)
      T0: begin
        if (Run) begin
          ctrl.ir_in = 1'b1;
          state_d    = T1;
        end
      end
      T1: begin
        case (op)
          OP_MV: begin
            ctrl.r_out[ry] = 1'b1;
            ctrl.r_in[rx]  = 1'b1;
            ctrl.done      = 1'b1;
          end
          OP_MVI: begin
            ctrl.din_out   = 1'b1;
            ctrl.r_in[rx]  = 1'b1;
            ctrl.done      = 1'b1;
          end
          OP_MVNZ: begin
            ctrl.r_out[ry] = 1'b1;
            ctrl.r_in[rx]  = ~flags_q[FZ];
            ctrl.done      = 1'b1;
          end
          default: begin
            ctrl.r_out[rx] = 1'b1;
            ctrl.a_in      = 1'b1;
            state_d        = T2;
          end
        endcase
      end
      T2: begin
        // Shift has no second operand, so the bus stays idle here
        if (op != OP_SL) begin
          ctrl.r_out[ry] = 1'b1;
        end
        ctrl.g_in = 1'b1;
        state_d   = T3;
      end
      T3: begin
        ctrl.g_out    = 1'b1;
        ctrl.r_in[rx] = 1'b1;
        ctrl.done     = 1'b1;
      end
      default: state_d = T0;
    endcase
    if (ctrl.done) begin
      state_d = T0;
    end
  end

  // One-hot bus mux: AND-OR of enabled sources, 0 when nothing drives
  always_comb begin
    bus = '0;
    for (int k = 0; k < int'(NUM_REGS); k++) begin
      bus = bus | (r_q[k] & {W{ctrl.r_out[k]}});
    end
    bus = bus | (DIN & {W{ctrl.din_out}});
    bus = bus | (g_q & {W{ctrl.g_out}});
  end

  proc_alu #(.W(W)) u_alu (
    .op_i (op),
    .a_i  (a_q),
    .b_i  (bus),
    .s_o  (alu_s),
    .z_o  (alu_z),
    .n_o  (alu_n),
    .c_o  (alu_c)
  );

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state_q <= T0;
      ir_q    <= '0;
      a_q     <= '0;
      g_q     <= '0;
      flags_q <= '0;
      for (int k = 0; k < int'(NUM_REGS); k++) begin
        r_q[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      if (ctrl.ir_in) begin
        ir_q <= DIN[W-1 -: IR_W];
      end
      if (ctrl.a_in) begin
        a_q <= bus;
      end
      if (ctrl.g_in) begin
        g_q     <= alu_s;
        flags_q <= {alu_z, alu_n, alu_c};
      end
      for (int k = 0; k < int'(NUM_REGS); k++) begin
        if (ctrl.r_in[k]) begin
          r_q[k] <= bus;
        end
      end
    end
  end

  assign Done     = ctrl.done;
  assign BusWires = bus;
  assign Flags    = flags_q;

endmodule
